// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue front end: select codes,
// RV32 opcode/funct fields, FSM states and the decoded-instruction record.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_SLTU = 3'b101;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_SLTU = 3'b011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] sel;
        logic       ill;
        logic       use_imm;
    } dec_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, cleared by reset; x0 is never written and always reads zero.
module alu_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RAW-1:0]  ra1_i,
    input  logic [RAW-1:0]  ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [RAW-1:0]  wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the 32-bit ALU: decodes RV32 ALU ops, reads operands,
// drives the combinational ALU for one cycle and reports the writeback.
module alu_issue_unit #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int RAW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_sel,
    input  logic [XLEN-1:0] alu_result,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res_data,
    output logic [4:0]      res_rd,
    output logic            res_illegal
);
    import alu_pkg::*;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t       d;
        logic [6:0] opc;
        logic [6:0] f7;
        logic [2:0] f3;
        logic       alu_f3;
        opc       = ins[6:0];
        f3        = ins[14:12];
        f7        = ins[31:25];
        d.ill     = 1'b1;
        d.use_imm = 1'b0;
        case (f3)
            F3_XOR:  d.sel = ALU_XOR;
            F3_AND:  d.sel = ALU_AND;
            F3_SLTU: d.sel = ALU_SLTU;
            default: d.sel = ALU_ADD;
        endcase
        alu_f3 = (f3 == F3_ADD) || (f3 == F3_XOR) || (f3 == F3_AND) || (f3 == F3_SLTU);
        if (opc == OPC_OP) begin
            if ((f7 == F7_BASE) && alu_f3) begin
                d.ill = 1'b0;
            end else if ((f7 == F7_SUB) && (f3 == F3_ADD)) begin
                d.ill = 1'b0;
                d.sel = ALU_SUB;
            end
        end else if (opc == OPC_OPIMM) begin
            d.use_imm = 1'b1;
            d.ill     = !alu_f3;
        end
        // RV32E builds reject indices beyond the implemented register count
        if ((32'(ins[11:7]) >= NREG) || (32'(ins[19:15]) >= NREG) ||
            (!d.use_imm && (32'(ins[24:20]) >= NREG))) begin
            d.ill = 1'b1;
        end
        if (d.ill) begin
            d.sel = ALU_ADD;
        end
        return d;
    endfunction

    state_e          state_q;
    logic [XLEN-1:0] alu_a_q, alu_b_q;
    logic [2:0]      alu_sel_q;
    logic [4:0]      rd_q;
    logic            ill_q;
    logic            res_valid_q, res_illegal_q;
    logic [XLEN-1:0] res_data_q;
    logic [4:0]      res_rd_q;

    dec_t            dec;
    logic [4:0]      rs1_idx, rs2_idx;
    logic [XLEN-1:0] rs1_val, rs2_val, imm;
    logic [XLEN-1:0] op_a_d, op_b_d;
    logic [2:0]      sel_d;
    logic            accept;
    logic            wb_en;

    assign dec     = decode(instr);
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];
    assign imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};

    // Illegal instructions park the ALU on ADD with zero operands
    always_comb begin
        op_a_d = rs1_val;
        op_b_d = dec.use_imm ? imm : rs2_val;
        sel_d  = dec.sel;
        if (dec.ill) begin
            op_a_d = '0;
            op_b_d = '0;
        end
    end

    assign instr_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && res_ready);
    assign accept      = instr_valid && instr_ready;
    assign wb_en       = (state_q == ST_EXEC) && !ill_q;

    alu_regfile #(
        .XLEN (XLEN),
        .NREG (NREG),
        .RAW  (RAW)
    ) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (rs1_idx[RAW-1:0]),
        .ra2_i (rs2_idx[RAW-1:0]),
        .rd1_o (rs1_val),
        .rd2_o (rs2_val),
        .we_i  (wb_en),
        .wa_i  (rd_q[RAW-1:0]),
        .wd_i  (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_sel_q     <= ALU_ADD;
            rd_q          <= '0;
            ill_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= op_a_d;
                alu_b_q   <= op_b_d;
                alu_sel_q <= sel_d;
                rd_q      <= instr[11:7];
                ill_q     <= dec.ill;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_valid_q   <= 1'b1;
                    res_data_q    <= ill_q ? '0 : alu_result;
                    res_rd_q      <= rd_q;
                    res_illegal_q <= ill_q;
                    state_q       <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= accept ? ST_EXEC : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_illegal = res_illegal_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: directed scenarios plus random
// instruction streams compared every cycle against an instruction-level model.
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_sel;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_illegal;

    alu_issue_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .res_illegal (res_illegal)
    );

    always #5 clk = ~clk;

    // Combinational ALU attached to the unit
    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = (alu_a < alu_b) ? 32'h1 : 32'h0;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        int          acc;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  sel;
        bit          lit_en;
        logic [31:0] lit;
        bit          sel_en;
        logic [2:0]  lit_sel;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    int          n_chk = 0;
    int          n_err = 0;
    int          edge_cnt = 0;
    int          acc_cnt = 0;
    bit          rnd_rr = 1'b0;
    bit          nxt_lit_en, nxt_sel_en;
    logic [31:0] nxt_lit;
    logic [2:0]  nxt_lit_sel;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    // Instruction-level semantics: what the result, operands and select must be
    function automatic exp_t model(input logic [31:0] ins);
        exp_t        e;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [31:0] a, b, r;
        bit          known;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        a     = mregs[ins[19:15]];
        b     = 32'h0;
        e.rd  = ins[11:7];
        e.ill = 1'b1;
        known = (f3 == 3'd0) || (f3 == 3'd4) || (f3 == 3'd7) || (f3 == 3'd3);
        if (opc == 7'h33) begin
            b     = mregs[ins[24:20]];
            e.ill = !(((f7 == 7'h00) && known) || ((f7 == 7'h20) && (f3 == 3'd0)));
        end else if (opc == 7'h13) begin
            b     = {{20{ins[31]}}, ins[31:20]};
            e.ill = !known;
        end
        if (f3 == 3'd0 && opc == 7'h33 && f7 == 7'h20) begin
            r = a - b; e.sel = 3'b001;
        end else if (f3 == 3'd4) begin
            r = a ^ b; e.sel = 3'b011;
        end else if (f3 == 3'd7) begin
            r = a & b; e.sel = 3'b010;
        end else if (f3 == 3'd3) begin
            r = (a < b) ? 32'h1 : 32'h0; e.sel = 3'b101;
        end else begin
            r = a + b; e.sel = 3'b000;
        end
        e.data    = e.ill ? 32'h0 : r;
        e.a       = a;
        e.b       = b;
        e.acc     = 0;
        e.lit_en  = 1'b0;
        e.lit     = 32'h0;
        e.sel_en  = 1'b0;
        e.lit_sel = 3'b000;
        return e;
    endfunction

    always @(posedge clk) edge_cnt++;

    // Compare process: one pass per cycle, mid-cycle
    always @(negedge clk) begin : compare
        bit   exp_rdy;
        bit   res_phase;
        exp_t e;
        if (!rst) begin
            exp_rdy   = 1'b1;
            res_phase = 1'b0;
            if (q.size() == 0) begin
                chk("res_valid idle", res_valid, 0);
            end else if (edge_cnt == q[0].acc + 1) begin
                exp_rdy = 1'b0;
                chk("res_valid exec", res_valid, 0);
                if (!q[0].ill) begin
                    chk("alu_a", alu_a, q[0].a);
                    chk("alu_b", alu_b, q[0].b);
                    chk("alu_sel", alu_sel, q[0].sel);
                end
                if (q[0].sel_en) chk("alu_sel literal", alu_sel, q[0].lit_sel);
            end else begin
                res_phase = 1'b1;
                exp_rdy   = res_ready;
                chk("res_valid", res_valid, 1);
                chk("res_data", res_data, q[0].data);
                chk("res_rd", res_rd, q[0].rd);
                chk("res_illegal", res_illegal, q[0].ill);
                if (q[0].lit_en && edge_cnt == q[0].acc + 2)
                    chk("res_data literal", res_data, q[0].lit);
            end
            chk("instr_ready", instr_ready, exp_rdy);
            if (res_phase && res_ready) void'(q.pop_front());
            if (instr_valid && exp_rdy) begin
                e = model(instr);
                e.acc     = edge_cnt;
                e.lit_en  = nxt_lit_en;
                e.lit     = nxt_lit;
                e.sel_en  = nxt_sel_en;
                e.lit_sel = nxt_lit_sel;
                if (!e.ill && e.rd != 5'd0) mregs[e.rd] = e.data;
                q.push_back(e);
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rr) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offer one instruction and return just after the edge that accepts it
    task automatic issue(input logic [31:0] ins, input bit len, input logic [31:0] ldata,
                         input bit sen, input logic [2:0] lsel);
        int start;
        bit got;
        start       = acc_cnt;
        got         = 1'b0;
        nxt_lit_en  = len;
        nxt_lit     = ldata;
        nxt_sel_en  = sen;
        nxt_lit_sel = lsel;
        instr       = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (acc_cnt != start) got = 1'b1;
        end
        n_chk++;
        if (!got) begin
            n_err++;
            $display("FAIL issue accept: instr %h not accepted, required within 60 cycles", ins);
        end
        instr_valid = 1'b0;
        nxt_lit_en  = 1'b0;
        nxt_sel_en  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        q.delete();
    endtask

    function automatic logic [31:0] rand_instr();
        int         k;
        logic [2:0] f3;
        logic [2:0] f3s [4];
        f3s[0] = 3'd0; f3s[1] = 3'd4; f3s[2] = 3'd7; f3s[3] = 3'd3;
        k  = $urandom_range(0, 9);
        f3 = f3s[$urandom_range(0, 3)];
        if (k < 4)
            return r_ins((f3 == 3'd0 && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), f3,
                         5'($urandom_range(0, 7)));
        else if (k < 8)
            return i_ins(12'($urandom), 5'($urandom_range(0, 7)), f3, 5'($urandom_range(0, 7)));
        else if (k == 8)
            return $urandom;
        else
            return r_ins(7'($urandom_range(0, 1) ? 7'h01 : 7'h00), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 3'($urandom_range(1, 2)),
                         5'($urandom_range(0, 7)));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required end within 500000 time units");
        $fatal(1);
    end

    initial begin
        int start;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        res_ready   = 1'b1;
        nxt_lit_en  = 1'b0;
        nxt_sel_en  = 1'b0;
        nxt_lit     = 32'h0;
        nxt_lit_sel = 3'b000;
        clear_model();
        @(posedge clk);
        #1;
        chk("reset alu_a", alu_a, 0);
        chk("reset alu_b", alu_b, 0);
        chk("reset alu_sel", alu_sel, 0);
        chk("reset res_valid", res_valid, 0);
        chk("reset res_data", res_data, 0);
        chk("reset res_rd", res_rd, 0);
        chk("reset res_illegal", res_illegal, 0);
        chk("reset instr_ready", instr_ready, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(i_ins(12'd5, 5'd0, 3'd0, 5'd1), 1, 32'h5, 1, 3'b000);
        issue(i_ins(12'hFFD, 5'd0, 3'd0, 5'd2), 1, 32'hFFFF_FFFD, 1, 3'b000);
        issue(r_ins(7'h20, 5'd2, 5'd1, 3'd0, 5'd3), 1, 32'h8, 1, 3'b001);
        issue(r_ins(7'h00, 5'd2, 5'd1, 3'd4, 5'd4), 1, 32'hFFFF_FFF8, 1, 3'b011);
        issue(r_ins(7'h00, 5'd2, 5'd1, 3'd7, 5'd5), 1, 32'h5, 1, 3'b010);
        issue(r_ins(7'h00, 5'd2, 5'd1, 3'd3, 5'd6), 1, 32'h1, 1, 3'b101);
        issue(r_ins(7'h00, 5'd2, 5'd1, 3'd6, 5'd7), 1, 32'h0, 0, 3'b000);
        issue(r_ins(7'h00, 5'd0, 5'd7, 3'd0, 5'd8), 1, 32'h0, 0, 3'b000);
        issue(i_ins(12'd9, 5'd0, 3'd0, 5'd0), 1, 32'h9, 0, 3'b000);
        issue(r_ins(7'h00, 5'd0, 5'd0, 3'd0, 5'd9), 1, 32'h0, 0, 3'b000);

        // Consumer stalls: the held result must not let a new instruction in
        wait_idle();
        res_ready = 1'b0;
        issue(i_ins(12'h123, 5'd1, 3'd0, 5'd10), 1, 32'h128, 0, 3'b000);
        instr       = r_ins(7'h00, 5'd10, 5'd1, 3'd0, 5'd11);
        instr_valid = 1'b1;
        start       = acc_cnt;
        repeat (6) tick();
        chk("stall accept count", acc_cnt, start);
        res_ready = 1'b1;
        issue(r_ins(7'h00, 5'd10, 5'd1, 3'd0, 5'd11), 1, 32'h12D, 0, 3'b000);

        // Reset lands while ADDI x1,x0,7 is executing
        wait_idle();
        issue(i_ins(12'd7, 5'd0, 3'd0, 5'd1), 0, 32'h0, 0, 3'b000);
        #2 rst = 1'b1;
        clear_model();
        #1;
        chk("mid-reset res_valid", res_valid, 0);
        chk("mid-reset alu_b", alu_b, 0);
        chk("mid-reset alu_sel", alu_sel, 0);
        chk("mid-reset res_data", res_data, 0);
        chk("mid-reset instr_ready", instr_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        issue(r_ins(7'h00, 5'd0, 5'd1, 3'd0, 5'd2), 1, 32'h0, 0, 3'b000);

        rnd_rr = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                instr_valid = 1'b0;
                tick();
            end
            issue(rand_instr(), 0, 32'h0, 0, 3'b000);
        end
        rnd_rr      = 1'b0;
        res_ready   = 1'b1;
        instr_valid = 1'b0;
        wait_idle();
        repeat (3) tick();
        n_chk++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
